// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one rv_mem port, with block locking and read-ID routing.
// Optional protocol error flag: define RV_MEM_ARBITER_ERROR_EN.
module rv_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_block,
    input  logic [NUM_PORTS-1:0]            req_op,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    output logic                            mem_valid,
    output logic                            mem_block,
    output logic                            mem_op,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_data,
    input  logic                            mem_ready,
    input  logic                            rsp_in_valid,
    input  logic [DATA_WIDTH-1:0]           rsp_in_data,
    output logic                            rsp_in_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    input  logic [NUM_PORTS-1:0]            rsp_ready,
    output logic                            err
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(READ_DEPTH + 1);
    localparam int PTR_W = $clog2(READ_DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [IDX_W-1:0] ids_q [READ_DEPTH];
    logic [IDX_W-1:0] ids_d [READ_DEPTH];

    logic [NUM_PORTS-1:0] elig;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     head;
    logic                 found;
    logic                 gnt_ok;
    logic                 full;
    logic                 empty;
    logic                 hs;
    logic                 push;
    logic                 pop;

    assign full  = (cnt_q == CNT_W'(READ_DEPTH));
    assign empty = (cnt_q == '0);
    assign elig  = req_valid & ~(req_op & {NUM_PORTS{full}});

    always_comb begin
        grant  = owner_q;
        cand   = '0;
        found  = 1'b0;
        gnt_ok = 1'b0;
        case (state_q)
            IDLE: begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    cand = IDX_W'((int'(last_q) + k) % NUM_PORTS);
                    if (!found && elig[cand]) begin
                        grant = cand;
                        found = 1'b1;
                    end
                end
                gnt_ok = found;
            end
            // Frozen grant: the request was already presented, FIFO cannot fill meanwhile.
            HOLD:    gnt_ok = req_valid[owner_q];
            LOCKED:  gnt_ok = elig[owner_q];
            default: gnt_ok = 1'b0;
        endcase
    end

    assign mem_valid = rst_n & gnt_ok;
    assign mem_block = req_block[grant];
    assign mem_op    = req_op[grant];
    assign mem_addr  = req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_data  = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
    assign hs        = mem_valid & mem_ready;
    assign push      = hs & mem_op;

    always_comb begin
        req_ready = '0;
        if (mem_valid) req_ready[grant] = mem_ready;
    end

    assign head         = ids_q[rd_q];
    assign rsp_data     = rsp_in_data;
    assign rsp_in_ready = rst_n & ~empty & rsp_ready[head];
    assign pop          = rsp_in_valid & rsp_in_ready;

    always_comb begin
        rsp_valid = '0;
        if (rst_n && !empty) rsp_valid[head] = rsp_in_valid;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = hs ? grant : last_q;
        case (state_q)
            IDLE: begin
                if (mem_valid && !mem_ready) begin
                    state_d = HOLD;
                    owner_d = grant;
                end else if (hs && mem_block) begin
                    state_d = LOCKED;
                    owner_d = grant;
                end
            end
            HOLD: begin
                if (!req_valid[owner_q]) state_d = IDLE;
                else if (hs) state_d = mem_block ? LOCKED : IDLE;
            end
            LOCKED: begin
                if (hs && !mem_block) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ids_d = ids_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            ids_d[wr_q] = grant;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) rd_d = rd_q + PTR_W'(1);
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < READ_DEPTH; i++) ids_q[i] <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ids_q   <= ids_d;
        end
    end

`ifdef RV_MEM_ARBITER_ERROR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (rsp_in_valid & empty)
              | ((state_q == HOLD) & ~req_valid[owner_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: rotation, hold, lock, FIFO full, routing, err.
module tb_rv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_block;
    logic [1:0]  req_op;
    logic [19:0] req_addr;
    logic [63:0] req_data;
    logic        mem_valid;
    logic        mem_block;
    logic        mem_op;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rsp_in_valid;
    logic [31:0] rsp_in_data;
    logic        rsp_in_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_ready;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_err;
    logic [1:0] exp_rv [3];

    rv_mem_arbiter #(
        .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_block(req_block), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .mem_valid(mem_valid), .mem_block(mem_block), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data),
        .rsp_in_ready(rsp_in_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef RV_MEM_ARBITER_ERROR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        exp_rv[0] = 2'b01;
        exp_rv[1] = 2'b10;
        exp_rv[2] = 2'b01;

        rst_n = 0; req_valid = 2'b11; req_block = 0; req_op = 0;
        req_addr = {10'h020, 10'h010};
        req_data = {32'hB1, 32'hA0};
        mem_ready = 1; rsp_in_valid = 1; rsp_in_data = 0; rsp_ready = 2'b11;
        #3;
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_in_ready", rsp_in_ready, 0);
        check("rst_err", err, 0);
        rsp_in_valid = 0;
        step();
        rst_n = 1;

        // alternating writes
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_valid", mem_valid, 1);
            check("rr_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
            check("rr_addr", mem_addr, (i % 2) ? 10'h020 : 10'h010);
            check("rr_data", mem_data, (i % 2) ? 32'hB1 : 32'hA0);
            step();
        end
        req_valid = 0;

        // port 1 read stalled, port 0 waiting
        req_op = 2'b10; req_addr[19:10] = 10'h030;
        req_valid = 2'b10; mem_ready = 0;
        #1;
        check("hold_addr0", mem_addr, 10'h030);
        check("hold_ready0", req_ready, 2'b00);
        step();
        req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("hold_valid", mem_valid, 1);
            check("hold_addr", mem_addr, 10'h030);
            check("hold_ready", req_ready, 2'b00);
            step();
        end
        mem_ready = 1;
        #1;
        check("hold_hs_ready", req_ready, 2'b10);
        check("hold_hs_op", mem_op, 1);
        step();
        #1;
        check("hold_next_ready", req_ready, 2'b01);
        check("hold_next_addr", mem_addr, 10'h010);
        step();
        req_valid = 0;
        rsp_in_valid = 1; rsp_in_data = 32'hCAFE;
        #1;
        check("hold_rsp_valid", rsp_valid, 2'b10);
        check("hold_rsp_in_ready", rsp_in_ready, 1);
        check("hold_rsp_data", rsp_data, 32'hCAFE);
        step();
        rsp_in_valid = 0;

        // block lock: port 0 block=1,1,0
        req_op = 0; req_block = 2'b01; req_valid = 2'b01;
        #1;
        check("lk1_ready", req_ready, 2'b01);
        check("lk1_block", mem_block, 1);
        step();
        req_valid = 2'b11;
        #1;
        check("lk2_ready", req_ready, 2'b01);
        step();
        req_block = 0;
        #1;
        check("lk3_ready", req_ready, 2'b01);
        check("lk3_block", mem_block, 0);
        step();
        #1;
        check("lk_p1_ready", req_ready, 2'b10);
        step();
        req_valid = 0;

        // fill read FIFO from port 1
        req_op = 2'b10; req_valid = 2'b10; req_addr[19:10] = 10'h040;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fill_ready", req_ready, 2'b10);
            step();
        end
        #1;
        check("full_ready", req_ready, 2'b00);
        check("full_mem_valid", mem_valid, 0);
        rsp_in_valid = 1; rsp_in_data = 32'h1111;
        #1;
        check("full_rsp_valid", rsp_valid, 2'b10);
        check("full_ready_pop", req_ready, 2'b00);
        step();
        rsp_in_valid = 0;
        #1;
        check("full_after_pop", req_ready, 2'b10);
        step();
        req_valid = 0;
        rsp_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_rsp_valid", rsp_valid, 2'b10);
            step();
        end
        rsp_in_valid = 0;
        #1;
        check("drain_empty", rsp_in_ready, 0);

        // read ordering 0,1,0
        req_op = 2'b11; req_valid = 2'b01;
        #1;
        check("ord_req0", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        #1;
        check("ord_req1", req_ready, 2'b10);
        step();
        req_valid = 2'b01;
        #1;
        check("ord_req2", req_ready, 2'b01);
        step();
        req_valid = 0;
        rsp_in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            rsp_in_data = 32'h100 + i;
            #1;
            check("ord_rsp_valid", rsp_valid, exp_rv[i]);
            check("ord_rsp_data", rsp_data, 32'h100 + i);
            step();
        end
        rsp_in_valid = 0;
        #1;
        check("err_clean", err, 0);

        // stray response with FIFO empty
        rsp_in_valid = 1;
        #1;
        check("stray_rsp_valid", rsp_valid, 2'b00);
        check("stray_in_ready", rsp_in_ready, 0);
        step();
        rsp_in_valid = 0;
        #1;
        check("err_set", err, exp_err);
        step();
        step();
        check("err_sticky", err, exp_err);
        rst_n = 0;
        #1;
        check("err_rst", err, 0);
        step();
        rst_n = 1;
        step();
        check("err_after_rst", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
